// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals shared by the write-port arbiter.
// slave is the arbiter's view; master is the requester/FIFO environment's view.
interface fifo_wr_arbiter_if #(
  parameter int data_width = 8,
  parameter int num_req    = 4,
  parameter int id_width   = 2
);
  logic [num_req-1:0]            req_valid;
  logic [num_req*data_width-1:0] req_data;
  logic [num_req-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [data_width-1:0]         fifo_wdata;
  logic [id_width-1:0]           fifo_src;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_wdata, fifo_src
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_wdata, fifo_src
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port through a one-entry holding register.
// Define FIFO_WR_ARB_STATS_EN to add saturating per-requester accepted-word counters.
//
// state | meaning
// IDLE  | no burst owner; next winner comes from the round-robin scan
// BURST | owner keeps the port until max_burst words or it drops valid
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int num_req    = 4,
  parameter int id_width   = 2,
  parameter int max_burst  = 4
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.slave      bus,
  output logic                  busy,
  output logic [num_req*16-1:0] word_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [id_width-1:0]   owner;
  logic [id_width-1:0]   last_grant;
  logic [3:0]            burst_cnt;
  logic [3:0]            burst_nxt;
  logic                  hold_valid;
  logic [data_width-1:0] hold_data;
  logic [id_width-1:0]   hold_src;

  logic                  load_en;
  logic                  win_valid;
  logic [id_width-1:0]   winner;
  logic [id_width-1:0]   base;
  logic [id_width-1:0]   idx;
  logic [data_width-1:0] win_data;
  logic [num_req-1:0]    ready_vec;

  // While in BURST the scan base is the owner, so a release rotates past it in the same cycle.
  always_comb begin
    load_en   = !hold_valid || !bus.fifo_full;
    win_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    base      = (state == BURST) ? owner : last_grant;
    if (!rst && load_en) begin
      if (state == BURST && bus.req_valid[owner]) begin
        win_valid = 1'b1;
        winner    = owner;
      end else begin
        for (int k = 1; k <= num_req; k++) begin
          idx = id_width'((int'(base) + k) % num_req);
          if (!win_valid && bus.req_valid[idx]) begin
            win_valid = 1'b1;
            winner    = idx;
          end
        end
      end
    end
    ready_vec = '0;
    if (win_valid) ready_vec[winner] = 1'b1;
    win_data = bus.req_data[winner*data_width +: data_width];
  end

  assign burst_nxt      = burst_cnt + 4'd1;
  assign bus.req_ready  = ready_vec;
  assign bus.fifo_wr    = hold_valid && !bus.fifo_full;
  assign bus.fifo_wdata = hold_data;
  assign bus.fifo_src   = hold_src;
  assign busy           = hold_valid || (state == BURST);

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= id_width'(num_req - 1);
      burst_cnt  <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_src   <= '0;
    end else begin
      if (win_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= win_data;
        hold_src   <= winner;
      end else if (bus.fifo_wr) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (win_valid) begin
            if (max_burst > 1) begin
              state     <= BURST;
              owner     <= winner;
              burst_cnt <= 4'd1;
            end else begin
              last_grant <= winner;
            end
          end
        end
        BURST: begin
          if (load_en) begin
            if (bus.req_valid[owner]) begin
              if (burst_nxt < 4'(max_burst)) begin
                burst_cnt <= burst_nxt;
              end else begin
                state      <= IDLE;
                burst_cnt  <= '0;
                last_grant <= owner;
              end
            end else begin
              last_grant <= owner;
              if (win_valid) begin
                owner     <= winner;
                burst_cnt <= 4'd1;
              end else begin
                state     <= IDLE;
                burst_cnt <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < num_req; i++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge wr_clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (win_valid && winner == id_width'(i) && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign word_cnt[i*16 +: 16] = cnt;
  end
`else
  assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, max_burst 4) with hand-computed expectations.
// Requester i always presents data 8'hA0 + 16*i.
module tb_fifo_wr_arbiter;
  logic        wr_clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [63:0] word_cnt;
  int          errors = 0;
  int          checks = 0;

  fifo_wr_arbiter_if #(.data_width(8), .num_req(4), .id_width(2)) bus ();

  fifo_wr_arbiter #(.data_width(8), .num_req(4), .id_width(2), .max_burst(4)) dut (
    .wr_clk   (wr_clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_data  = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
    bus.fifo_full = 1'b0;

    // reset with every requester valid
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_wr",    32'(bus.fifo_wr), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_wdata", 32'(bus.fifo_wdata), 32'h0);
    chk("rst_src",   32'(bus.fifo_src), 32'h0);
    chk("rst_cnt",   32'(word_cnt[31:0] | word_cnt[63:32]), 32'h0);
    rst = 1'b0;
    #1;
    chk("first_ready", 32'(bus.req_ready), 32'h1);

    // burst rotation 0,0,0,0,1,1,1,1,...
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("rot_src",   32'(bus.fifo_src), 32'((k / 4) % 4));
      chk("rot_wdata", 32'(bus.fifo_wdata), 32'(8'hA0 + 8'(16 * ((k / 4) % 4))));
      chk("rot_wr",    32'(bus.fifo_wr), 32'h1);
      chk("rot_busy",  32'(busy), 32'h1);
    end

    // early release: req 1 gives two words then drops, req 3 takes over with no gap
    bus.req_valid = 4'b1010;
    #1;
    chk("er_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    chk("er_src_a", 32'(bus.fifo_src), 32'h1);
    tick();
    chk("er_src_b", 32'(bus.fifo_src), 32'h1);
    chk("er_wr_b",  32'(bus.fifo_wr), 32'h1);
    bus.req_valid = 4'b1000;
    #1;
    chk("er_ready3", 32'(bus.req_ready), 32'h8);
    tick();
    chk("er_src_c",   32'(bus.fifo_src), 32'h3);
    chk("er_wdata_c", 32'(bus.fifo_wdata), 32'hD0);
    chk("er_wr_c",    32'(bus.fifo_wr), 32'h1);

    // backpressure during a req 2 burst at burst_cnt 2
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    tick();
    chk("bp_src", 32'(bus.fifo_src), 32'h2);
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_ready", 32'(bus.req_ready), 32'h0);
      chk("bp_hold_wr",    32'(bus.fifo_wr), 32'h0);
      tick();
      chk("bp_hold_src",   32'(bus.fifo_src), 32'h2);
      chk("bp_hold_wdata", 32'(bus.fifo_wdata), 32'hC0);
      chk("bp_hold_busy",  32'(busy), 32'h1);
    end
    // req 0 joins; owner 2 still has exactly two words left in its burst
    bus.fifo_full = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    chk("bp_rel_wr",    32'(bus.fifo_wr), 32'h1);
    chk("bp_rel_ready", 32'(bus.req_ready), 32'h4);
    tick();
    chk("bp_src_3", 32'(bus.fifo_src), 32'h2);
    tick();
    chk("bp_src_4", 32'(bus.fifo_src), 32'h2);
    chk("bp_next_ready", 32'(bus.req_ready), 32'h1);
    tick();
    chk("bp_src_rot", 32'(bus.fifo_src), 32'h0);

    // reset while req 2 owns the port at burst_cnt 2
    bus.req_valid = 4'b0100;
    tick();
    tick();
    chk("mr_src", 32'(bus.fifo_src), 32'h2);
    rst = 1'b1;
    bus.req_valid = 4'b0101;
    tick();
    chk("mr_wr",    32'(bus.fifo_wr), 32'h0);
    chk("mr_busy",  32'(busy), 32'h0);
    chk("mr_ready", 32'(bus.req_ready), 32'h0);
    chk("mr_wdata", 32'(bus.fifo_wdata), 32'h0);
    rst = 1'b0;
    #1;
    chk("mr_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    chk("mr_src0",   32'(bus.fifo_src), 32'h0);
    chk("mr_wdata0", 32'(bus.fifo_wdata), 32'hA0);

`ifdef FIFO_WR_ARB_STATS_EN
    rst = 1'b1;
    bus.req_valid = 4'b0010;
    tick();
    rst = 1'b0;
    chk("st_clr", 32'(word_cnt[31:0] | word_cnt[63:32]), 32'h0);
    for (int k = 0; k < 10; k++) tick();
    chk("st_cnt10", 32'(word_cnt[31:16]), 32'd10);
    for (int k = 0; k < 66000; k++) tick();
    chk("st_sat",    32'(word_cnt[31:16]), 32'hFFFF);
    chk("st_other0", 32'(word_cnt[15:0]), 32'h0);
    chk("st_other2", 32'(word_cnt[47:32]), 32'h0);
    chk("st_other3", 32'(word_cnt[63:48]), 32'h0);
`else
    chk("st_off", 32'(word_cnt[31:0] | word_cnt[63:32]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
